// File: rtl/oric_sdram_bridge.sv
// Bridges the Oric core's RAM strobes onto the sdram controller's toggle-handshake port,
// with one request in flight and a single pending slot behind it.
module oric_sdram_bridge #(
    parameter int AW        = 16,
    parameter bit CS_GATE_Q = 1'b1
) (
    input  logic          clk_in,
    input  logic          RESET,
    input  logic [AW-1:0] ram_ad,
    input  logic [7:0]    ram_d,
    input  logic          ram_cs,
    input  logic          ram_oe,
    input  logic          ram_we,
    output logic [7:0]    ram_q,
    output logic          port_req,
    input  logic          port_ack,
    output logic [AW-1:0] port_a,
    output logic          port_we,
    output logic [1:0]    port_ds,
    output logic [15:0]   port_d,
    input  logic [15:0]   port_q,
    output logic          busy,
    output logic          overrun
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state;
    logic          rd_p0, wr_p0;
    logic [AW-1:0] ad_p0;
    logic          pend_vld, pend_we;
    logic [AW-1:0] pend_a;
    logic [7:0]    pend_d;
    logic [7:0]    ram_q_reg;
    logic          own;

    logic          rd, wr, trig, done, from_pend;
    logic [AW-1:0] iss_a;
    logic          iss_we;
    logic [7:0]    iss_d;

    function automatic logic [1:0] ds_sel(input logic we, input logic a0);
        return we ? (a0 ? 2'b10 : 2'b01) : 2'b11;
    endfunction

    assign rd   = ram_cs & ram_oe;
    assign wr   = ram_cs & ram_we;
    assign trig = (rd & ~rd_p0) | (wr & ~wr_p0) | (rd & rd_p0 & (ram_ad != ad_p0));
    assign done = (port_ack == port_req);

    // A completing request hands the port to the pending slot first, else to a fresh trigger.
    assign from_pend = (state == S_WAIT) & done & pend_vld;
    assign iss_a     = from_pend ? pend_a  : ram_ad;
    assign iss_we    = from_pend ? pend_we : ram_we;
    assign iss_d     = from_pend ? pend_d  : ram_d;

    // Stage p0: strobe/address history for edge detection
    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            rd_p0 <= 1'b0;
            wr_p0 <= 1'b0;
            ad_p0 <= '0;
        end else begin
            rd_p0 <= rd;
            wr_p0 <= wr;
            ad_p0 <= ram_ad;
        end
    end

    always_ff @(posedge clk_in or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            port_req  <= 1'b0;
            port_a    <= '0;
            port_we   <= 1'b0;
            port_ds   <= 2'b11;
            port_d    <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_a    <= '0;
            pend_d    <= '0;
            ram_q_reg <= '0;
            own       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!done) begin
                        // Toggle left over from before reset: drain it without touching ram_q.
                        state <= S_WAIT;
                        busy  <= 1'b1;
                        if (trig) begin
                            pend_vld <= 1'b1;
                            pend_a   <= ram_ad;
                            pend_we  <= ram_we;
                            pend_d   <= ram_d;
                        end
                    end else if (trig) begin
                        port_a   <= iss_a;
                        port_we  <= iss_we;
                        port_ds  <= ds_sel(iss_we, iss_a[0]);
                        port_d   <= {iss_d, iss_d};
                        port_req <= ~port_req;
                        own      <= 1'b1;
                        state    <= S_WAIT;
                        busy     <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        if (own && !port_we)
                            ram_q_reg <= port_a[0] ? port_q[15:8] : port_q[7:0];
                        if (pend_vld || trig) begin
                            port_a   <= iss_a;
                            port_we  <= iss_we;
                            port_ds  <= ds_sel(iss_we, iss_a[0]);
                            port_d   <= {iss_d, iss_d};
                            port_req <= ~port_req;
                            own      <= 1'b1;
                            busy     <= 1'b1;
                            pend_vld <= pend_vld & trig;
                            if (pend_vld && trig) begin
                                pend_a  <= ram_ad;
                                pend_we <= ram_we;
                                pend_d  <= ram_d;
                            end
                        end else begin
                            state <= S_IDLE;
                            own   <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        busy <= 1'b1;
                        if (trig) begin
                            if (pend_vld)
                                overrun <= 1'b1;
                            pend_vld <= 1'b1;
                            pend_a   <= ram_ad;
                            pend_we  <= ram_we;
                            pend_d   <= ram_d;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    generate
        if (CS_GATE_Q) begin : g_gate
            assign ram_q = ram_cs ? ram_q_reg : 8'h00;
        end else begin : g_nogate
            assign ram_q = ram_q_reg;
        end
    endgenerate

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// Directed bench for oric_sdram_bridge with a small sdram ack responder and toggle monitor.
module tb_oric_sdram_bridge;

    logic        clk = 1'b0;
    logic        RESET;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic        ram_cs, ram_oe, ram_we;
    logic [7:0]  ram_q;
    logic        port_req, port_ack;
    logic [15:0] port_a;
    logic        port_we;
    logic [1:0]  port_ds;
    logic [15:0] port_d, port_q;
    logic        busy, overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic        rsp_en = 1'b0;
    int          rsp_lat = 5;
    logic [15:0] rsp_q = 16'h0000;
    logic        ack_manual = 1'b0;
    logic [15:0] q_manual = 16'h0000;
    logic        ack_model = 1'b0;
    logic [15:0] q_model = 16'h0000;
    int          cnt = 0;

    int          toggles = 0;
    logic        req_seen = 1'b0;
    logic [15:0] last_a = 16'h0000;

    assign port_ack = rsp_en ? ack_model : ack_manual;
    assign port_q   = rsp_en ? q_model : q_manual;

    oric_sdram_bridge #(.AW(16), .CS_GATE_Q(1'b1)) dut (
        .clk_in(clk), .RESET(RESET), .ram_ad(ram_ad), .ram_d(ram_d),
        .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we), .ram_q(ram_q),
        .port_req(port_req), .port_ack(port_ack), .port_a(port_a), .port_we(port_we),
        .port_ds(port_ds), .port_d(port_d), .port_q(port_q), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rsp_en) begin
            ack_model <= ack_manual;
            cnt <= 0;
        end else if (port_req != ack_model) begin
            if (cnt >= rsp_lat - 1) begin
                ack_model <= port_req;
                q_model <= rsp_q;
                cnt <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (port_req !== req_seen) begin
            toggles = toggles + 1;
            last_a = port_a;
        end
        req_seen = port_req;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 80; k++) begin
            step();
            if (!busy) break;
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL %s_timeout: busy got %b want 0", tag, busy); end
    endtask

    task automatic idle_inputs();
        ram_oe = 1'b0; ram_we = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        RESET = 1'b1; ram_cs = 1'b0; ram_oe = 1'b0; ram_we = 1'b0; ram_ad = 16'h0000; ram_d = 8'h00;
        step(); step();
        n_cmp++; if (port_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", port_req); end
        n_cmp++; if (port_ds !== 2'b11) begin n_err++; $display("FAIL rst_ds: got %b want 11", port_ds); end
        n_cmp++; if (port_a !== 16'h0000 || port_d !== 16'h0000 || port_we !== 1'b0) begin
            n_err++; $display("FAIL rst_port: a=%h d=%h we=%b want 0", port_a, port_d, port_we); end
        n_cmp++; if (busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: busy=%b overrun=%b want 0/0", busy, overrun); end
        n_cmp++; if (ram_q !== 8'h00) begin n_err++; $display("FAIL rst_q: got %h want 00", ram_q); end
        RESET = 1'b0;
        rsp_en = 1'b1;
        step(); step();
    endtask

    task automatic test_read();
        int t0;
        t0 = toggles; rsp_lat = 5; rsp_q = 16'hABCD;
        ram_cs = 1'b1; ram_ad = 16'h1235; ram_oe = 1'b1;
        step();
        n_cmp++; if (port_req !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b want 1", port_req); end
        n_cmp++; if (port_ds !== 2'b11 || port_we !== 1'b0 || port_a !== 16'h1235) begin
            n_err++; $display("FAIL rd_latch: ds=%b we=%b a=%h want 11/0/1235", port_ds, port_we, port_a); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rd_busy: got %b want 1", busy); end
        wait_idle("rd");
        n_cmp++; if (ram_q !== 8'hAB) begin n_err++; $display("FAIL rd_q: got %h want AB", ram_q); end
        n_cmp++; if (toggles - t0 !== 1) begin n_err++; $display("FAIL rd_toggles: got %0d want 1", toggles - t0); end
        idle_inputs();
        ram_cs = 1'b0; #1;
        n_cmp++; if (ram_q !== 8'h00) begin n_err++; $display("FAIL rd_csgate: got %h want 00", ram_q); end
        ram_cs = 1'b1; #1;
        n_cmp++; if (ram_q !== 8'hAB) begin n_err++; $display("FAIL rd_hold: got %h want AB", ram_q); end
    endtask

    task automatic test_write();
        int t0;
        t0 = toggles; rsp_lat = 4; rsp_q = 16'hFFFF;
        ram_ad = 16'h0400; ram_d = 8'h5A; ram_we = 1'b1;
        step();
        n_cmp++; if (port_we !== 1'b1 || port_ds !== 2'b01) begin
            n_err++; $display("FAIL wr_ctl: we=%b ds=%b want 1/01", port_we, port_ds); end
        n_cmp++; if (port_d !== 16'h5A5A || port_a !== 16'h0400) begin
            n_err++; $display("FAIL wr_data: d=%h a=%h want 5A5A/0400", port_d, port_a); end
        wait_idle("wr");
        n_cmp++; if (toggles - t0 !== 1) begin n_err++; $display("FAIL wr_toggles: got %0d want 1", toggles - t0); end
        n_cmp++; if (ram_q !== 8'hAB) begin n_err++; $display("FAIL wr_q: got %h want AB", ram_q); end
        idle_inputs();
    endtask

    task automatic test_addr_change();
        int t0;
        t0 = toggles; rsp_lat = 3; rsp_q = 16'hC3A5;
        ram_ad = 16'h0010; ram_oe = 1'b1;
        step();
        ram_ad = 16'h0011;
        step();
        n_cmp++; if (port_a !== 16'h0010 || toggles - t0 !== 1) begin
            n_err++; $display("FAIL ac_order: a=%h toggles=%0d want 0010/1", port_a, toggles - t0); end
        wait_idle("ac");
        n_cmp++; if (toggles - t0 !== 2 || last_a !== 16'h0011) begin
            n_err++; $display("FAIL ac_issue: toggles=%0d last=%h want 2/0011", toggles - t0, last_a); end
        n_cmp++; if (ram_q !== 8'hC3) begin n_err++; $display("FAIL ac_q: got %h want C3", ram_q); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ac_ovr: got %b want 0", overrun); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = toggles; rsp_lat = 8; rsp_q = 16'h7E81;
        ram_ad = 16'h0100; ram_oe = 1'b1;
        step();
        ram_ad = 16'h0101;
        step();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_ovr_early: got %b want 0", overrun); end
        ram_ad = 16'h0102;
        step();
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_ovr: got %b want 1", overrun); end
        n_cmp++; if (toggles - t0 !== 1 || port_a !== 16'h0100) begin
            n_err++; $display("FAIL b2b_first: toggles=%0d a=%h want 1/0100", toggles - t0, port_a); end
        wait_idle("b2b");
        n_cmp++; if (toggles - t0 !== 2 || last_a !== 16'h0102) begin
            n_err++; $display("FAIL b2b_issue: toggles=%0d last=%h want 2/0102", toggles - t0, last_a); end
        n_cmp++; if (ram_q !== 8'h81) begin n_err++; $display("FAIL b2b_q: got %h want 81", ram_q); end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        int t0;
        ack_manual = port_ack; q_manual = 16'h0000; rsp_en = 1'b0;
        step();
        t0 = toggles;
        ram_ad = 16'h0200; ram_oe = 1'b1;
        step();
        n_cmp++; if (toggles - t0 !== 1 || port_a !== 16'h0200) begin
            n_err++; $display("FAIL sim_first: toggles=%0d a=%h want 1/0200", toggles - t0, port_a); end
        q_manual = 16'h1122; ack_manual = port_req; ram_ad = 16'h0203;
        step();
        n_cmp++; if (toggles - t0 !== 2 || port_a !== 16'h0203) begin
            n_err++; $display("FAIL sim_issue: toggles=%0d a=%h want 2/0203", toggles - t0, port_a); end
        n_cmp++; if (ram_q !== 8'h22 || busy !== 1'b1) begin
            n_err++; $display("FAIL sim_mid: q=%h busy=%b want 22/1", ram_q, busy); end
        q_manual = 16'h3344; ack_manual = port_req;
        step();
        n_cmp++; if (ram_q !== 8'h33 || busy !== 1'b0) begin
            n_err++; $display("FAIL sim_end: q=%h busy=%b want 33/0", ram_q, busy); end
        n_cmp++; if (overrun !== 1'b1 || toggles - t0 !== 2) begin
            n_err++; $display("FAIL sim_sticky: ovr=%b toggles=%0d want 1/2", overrun, toggles - t0); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        q_manual = 16'h9955; ram_ad = 16'h0300; ram_oe = 1'b1;
        step();
        ack_manual = port_req;
        step();
        n_cmp++; if (ram_q !== 8'h55) begin n_err++; $display("FAIL rm_pre_q: got %h want 55", ram_q); end
        ram_oe = 1'b0;
        step();
        ram_ad = 16'h0301; ram_oe = 1'b1;
        step();
        ack_manual = 1'b1;
        ram_cs = 1'b0; ram_oe = 1'b0; #1;
        n_cmp++; if (ram_q !== 8'h00) begin n_err++; $display("FAIL rm_csgate: got %h want 00", ram_q); end
        RESET = 1'b1; #1;
        n_cmp++; if (port_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL rm_clear: req=%b busy=%b ovr=%b want 0/0/0", port_req, busy, overrun); end
        n_cmp++; if (port_a !== 16'h0000 || port_ds !== 2'b11 || port_d !== 16'h0000) begin
            n_err++; $display("FAIL rm_port: a=%h ds=%b d=%h want 0000/11/0000", port_a, port_ds, port_d); end
        step();
        RESET = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b1 || ram_q !== 8'h00) begin
            n_err++; $display("FAIL rm_drain: busy=%b q=%h want 1/00", busy, ram_q); end
        step(); step(); step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_hold: busy=%b want 1", busy); end
        q_manual = 16'hEEEE; ack_manual = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0 || port_req !== 1'b0) begin
            n_err++; $display("FAIL rm_done: busy=%b req=%b want 0/0", busy, port_req); end
        ram_cs = 1'b1; #1;
        n_cmp++; if (ram_q !== 8'h00) begin n_err++; $display("FAIL rm_noupd: got %h want 00", ram_q); end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_addr_change();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
